// File: rtl/wb_regfile.sv
// Writeback-stage register file: 15 GPRs with write-through read bypass,
// R15 reads as PC+8, registered fetch redirect and a retired-write counter.
module wb_regfile #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             PCSrcW,
  input  logic             RegWriteW,
  input  logic             MemtoRegW,
  input  logic [31:0]      ReadDataW,
  input  logic [31:0]      ALUResultW,
  input  logic [31:0]      BranchResultW,
  input  logic [3:0]       WA3W,
  input  logic [3:0]       RA1D,
  input  logic [3:0]       RA2D,
  input  logic [3:0]       RA3D,
  input  logic [31:0]      PCPlus8D,
  output logic [31:0]      RD1D,
  output logic [31:0]      RD2D,
  output logic [31:0]      RD3D,
  output logic [31:0]      ResultW,
  output logic             RedirectF,
  output logic [31:0]      PCTargetF,
  output logic [CNT_W-1:0] RetireCnt
);

  localparam logic [3:0] PC_IDX = 4'd15;

  logic [31:0]      regs_q [15];
  logic             redir_q, redir_d;
  logic [31:0]      target_q, target_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gpr_wr;

  assign ResultW = MemtoRegW ? ReadDataW : ALUResultW;
  assign gpr_wr  = RegWriteW && (WA3W != PC_IDX);

  // Bypass is gated by rst_n so reads during reset show the (cleared) storage.
  function automatic logic [31:0] rd_port(input logic [3:0] ra);
    if (ra == PC_IDX)
      return PCPlus8D;
    else if (rst_n && gpr_wr && (ra == WA3W))
      return ResultW;
    else
      return regs_q[ra];
  endfunction

  always_comb begin
    RD1D = rd_port(RA1D);
    RD2D = rd_port(RA2D);
    RD3D = rd_port(RA3D);
  end

  always_comb begin
    redir_d  = 1'b0;
    target_d = target_q;
    cnt_d    = cnt_q;
    if (PCSrcW) begin
      redir_d  = 1'b1;
      target_d = BranchResultW;
    end else if (RegWriteW && (WA3W == PC_IDX)) begin
      redir_d  = 1'b1;
      target_d = ResultW;
    end
    if (RegWriteW)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++)
        regs_q[i] <= '0;
      redir_q  <= 1'b0;
      target_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (gpr_wr)
        regs_q[WA3W] <= ResultW;
      redir_q  <= redir_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
    end
  end

  assign RedirectF = redir_q;
  assign PCTargetF = target_q;
  assign RetireCnt = cnt_q;

endmodule
